// File: rtl/osd_char_seq_if.sv
// Glyph-row request bus between osd_char_seq and the glyph ROM stage.
//   char_ascii      character code of the current request
//   char_row_index  glyph row of the current request
//   char_pos_x/y    origin of the current character
//   char_valid      request valid
//   char_next       request consumed; driven by the glyph stage
// master: the sequencer; slave: the glyph stage.
interface osd_char_seq_if;
   logic [7:0]  char_ascii;
   logic [5:0]  char_row_index;
   logic [10:0] char_pos_x;
   logic [10:0] char_pos_y;
   logic        char_valid;
   logic        char_next;

   modport master (
      output char_ascii, char_row_index, char_pos_x, char_pos_y, char_valid,
      input  char_next
   );

   modport slave (
      input  char_ascii, char_row_index, char_pos_x, char_pos_y, char_valid,
      output char_next
   );
endinterface

// File: rtl/osd_char_seq.sv
// OSD text sequencer: holds a text string and, on start, walks it character
// by character and glyph row by glyph row, issuing one request per row on req.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data        text buffer write port (always accepted)
//   start/len/origin_x/origin_y  render request (ignored while busy)
//   busy, done                   render in progress / one-cycle finish pulse
//   req                          glyph-row request bus (master side)
// Build option: define OSD_SKIP_BLANK_EN to emit no rows for codes outside
// 33..126 while still advancing the character position.
module osd_char_seq #(
   parameter int unsigned CHAR_W     = 9,
   parameter int unsigned CHAR_H     = 18,
   parameter int unsigned TEXT_DEPTH = 64,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned COLS       = 32,
   parameter int unsigned LINE_PITCH = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic [10:0]       origin_x,
   input  logic [10:0]       origin_y,
   output logic              busy,
   output logic              done,
   osd_char_seq_if.master    req
);

   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam int unsigned COL_W = $clog2(COLS + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_PRESENT = 3'd2;
   localparam logic [2:0] S_GAP     = 3'd3;
   localparam logic [2:0] S_FIN     = 3'd4;

   localparam logic [5:0]       ROW_LAST = 6'(CHAR_H - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(TEXT_DEPTH);
   localparam logic [COL_W-1:0] COL_WRAP = COL_W'(COLS);
   localparam logic [10:0]      X_STEP   = 11'(CHAR_W);
   localparam logic [10:0]      Y_STEP   = 11'(LINE_PITCH);

   logic [2:0]       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] k_q, k_d;
   logic [5:0]       row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [10:0]      org_x_q, org_x_d;
   logic [10:0]      x_q, x_d;
   logic [10:0]      y_q, y_d;
   logic [7:0]       ascii_q, ascii_d;
   logic             valid_q, valid_d;
   logic             busy_d, done_d;

   logic [7:0]       mem [TEXT_DEPTH];
   logic [7:0]       rd_data_c;
   logic             skip_c;
   logic             last_c;
   logic [COL_W-1:0] adv_col_c;
   logic [10:0]      adv_x_c;
   logic [10:0]      adv_y_c;

   // Text buffer; the read is sampled into ascii_q at the end of FETCH, so a
   // same-cycle write to the same address yields the old code.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data_c = mem[k_q[ADDR_W-1:0]];

`ifdef OSD_SKIP_BLANK_EN
   assign skip_c = (rd_data_c < 8'd33) || (rd_data_c > 8'd126);
`else
   assign skip_c = 1'b0;
`endif

   assign last_c = ((k_q + LEN_W'(1)) == len_q);

   // Position of the next character: step right, or wrap to a new text line.
   always_comb begin
      adv_col_c = col_q + COL_W'(1);
      adv_x_c   = x_q + X_STEP;
      adv_y_c   = y_q;
      if (adv_col_c == COL_WRAP) begin
         adv_col_c = '0;
         adv_x_c   = org_x_q;
         adv_y_c   = y_q + Y_STEP;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      k_d     = k_q;
      row_d   = row_q;
      col_d   = col_q;
      org_x_d = org_x_q;
      x_d     = x_q;
      y_d     = y_q;
      ascii_d = ascii_q;
      valid_d = valid_q;
      busy_d  = busy;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = (len > LEN_MAX) ? LEN_MAX : len;
               k_d     = '0;
               row_d   = '0;
               col_d   = '0;
               org_x_d = origin_x;
               x_d     = origin_x;
               y_d     = origin_y;
               busy_d  = 1'b1;
               state_d = (len == '0) ? S_FIN : S_FETCH;
            end
         end
         S_FETCH: begin
            ascii_d = rd_data_c;
            if (skip_c) begin
               col_d = adv_col_c;
               x_d   = adv_x_c;
               y_d   = adv_y_c;
               if (last_c) state_d = S_FIN;
               else        k_d     = k_q + LEN_W'(1);
            end else begin
               valid_d = 1'b1;
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (req.char_next) begin
               valid_d = 1'b0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            // Single low cycle so the glyph stage sees a fresh rising edge.
            if (row_q != ROW_LAST) begin
               row_d   = row_q + 6'd1;
               valid_d = 1'b1;
               state_d = S_PRESENT;
            end else begin
               row_d = '0;
               col_d = adv_col_c;
               x_d   = adv_x_c;
               y_d   = adv_y_c;
               if (last_c) begin
                  state_d = S_FIN;
               end else begin
                  k_d     = k_q + LEN_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         k_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         org_x_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         ascii_q <= '0;
         valid_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         k_q     <= k_d;
         row_q   <= row_d;
         col_q   <= col_d;
         org_x_q <= org_x_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ascii_q <= ascii_d;
         valid_q <= valid_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   assign req.char_ascii     = ascii_q;
   assign req.char_row_index = row_q;
   assign req.char_pos_x     = x_q;
   assign req.char_pos_y     = y_q;
   assign req.char_valid     = valid_q;

endmodule

// File: tb/tb_osd_char_seq.sv
// Directed testbench for osd_char_seq: renders short strings with a
// one-cycle-echo downstream, plus stall, wrap, len=0, restart-while-busy,
// mid-render reset and blank-character scenarios.
`timescale 1ns/1ps
module tb_osd_char_seq;
   localparam int CHAR_H     = 18;
   localparam int CHAR_W     = 9;
   localparam int COLS       = 32;
   localparam int LINE_PITCH = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        start;
   logic [6:0]  len;
   logic [10:0] origin_x;
   logic [10:0] origin_y;
   logic        busy;
   logic        done;

   osd_char_seq_if req_if ();

   osd_char_seq dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .start    (start),
      .len      (len),
      .origin_x (origin_x),
      .origin_y (origin_y),
      .busy     (busy),
      .done     (done),
      .req      (req_if)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]  text_model [64];
   logic [7:0]  rec_a[$], exp_a[$];
   logic [5:0]  rec_r[$], exp_r[$];
   logic [10:0] rec_x[$], exp_x[$];
   logic [10:0] rec_y[$], exp_y[$];

   int   n_done, busy_bad, gap_err, stall_err, stall_hits, done_cyc, valid_seen;
   int   timeout, post_rst_done;
   logic busy_c1, post_rst_valid, post_rst_busy;

   task automatic write_char(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      text_model[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Reference request stream from the text model (closed-form positions).
   task automatic build_expected(input int n, input logic [10:0] ox, input logic [10:0] oy);
      exp_a.delete(); exp_r.delete(); exp_x.delete(); exp_y.delete();
      for (int i = 0; i < n; i++) begin
         logic [7:0] c;
         bit skip;
         c = text_model[i];
         skip = 1'b0;
`ifdef OSD_SKIP_BLANK_EN
         skip = (c < 8'd33) || (c > 8'd126);
`endif
         if (!skip) begin
            for (int r = 0; r < CHAR_H; r++) begin
               exp_a.push_back(c);
               exp_r.push_back(6'(r));
               exp_x.push_back(11'(int'(ox) + (i % COLS) * CHAR_W));
               exp_y.push_back(11'(int'(oy) + (i / COLS) * LINE_PITCH));
            end
         end
      end
   endtask

   // Start a render and act as the glyph stage (char_next = previous-cycle
   // char_valid), recording every accepted request until done or an abort.
   task automatic render(input logic [6:0] l, input logic [10:0] ox, input logic [10:0] oy,
                         input bit stall_en, input int rst_row, input bit restart);
      logic v, prev_v, hs_prev, stalled;
      int   stall_left, cyc;
      logic [7:0]  s_a;
      logic [5:0]  s_r;
      logic [10:0] s_x, s_y;
      rec_a.delete(); rec_r.delete(); rec_x.delete(); rec_y.delete();
      n_done = 0; busy_bad = 0; gap_err = 0; stall_err = 0; stall_hits = 0;
      done_cyc = -1; valid_seen = 0; timeout = 0; post_rst_done = 0;
      prev_v = 1'b0; hs_prev = 1'b0; stalled = 1'b0; stall_left = 0; cyc = 1;
      s_a = '0; s_r = '0; s_x = '0; s_y = '0;
      @(negedge clk);
      start = 1'b1; len = l; origin_x = ox; origin_y = oy;
      @(negedge clk);
      start = 1'b0;
      busy_c1 = busy;
      forever begin
         v = req_if.char_valid;
         if (restart) begin
            start = (cyc == 5);
            if (cyc == 5) begin len = 7'd5; origin_x = 11'd7; origin_y = 11'd7; end
         end
         if (hs_prev && v) gap_err++;
         if (stall_left > 0) begin
            if (v !== 1'b1 || req_if.char_ascii !== s_a || req_if.char_row_index !== s_r ||
                req_if.char_pos_x !== s_x || req_if.char_pos_y !== s_y) stall_err++;
            req_if.char_next = 1'b0;
            stall_left--;
         end else if (stall_en && !stalled && v && req_if.char_row_index == 6'd5) begin
            s_a = req_if.char_ascii; s_r = req_if.char_row_index;
            s_x = req_if.char_pos_x; s_y = req_if.char_pos_y;
            stalled = 1'b1; stall_hits++; stall_left = 10;
            req_if.char_next = 1'b0;
         end else begin
            req_if.char_next = prev_v;
         end
         hs_prev = v && req_if.char_next;
         if (hs_prev) begin
            rec_a.push_back(req_if.char_ascii);
            rec_r.push_back(req_if.char_row_index);
            rec_x.push_back(req_if.char_pos_x);
            rec_y.push_back(req_if.char_pos_y);
         end
         if (v) valid_seen++;
         if (done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
            if (busy !== 1'b0) busy_bad++;
         end
         prev_v = v;
         if (rst_row >= 0 && v && req_if.char_row_index == 6'(rst_row)) begin
            rst = 1'b1;
            req_if.char_next = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            post_rst_valid = req_if.char_valid;
            post_rst_busy  = busy;
            repeat (10) begin
               @(negedge clk);
               if (done === 1'b1) post_rst_done++;
            end
            break;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
         if (cyc > 4000) begin timeout = 1; break; end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      req_if.char_next = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      len = '0; origin_x = '0; origin_y = '0; req_if.char_next = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      tests_run++;
      if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, expected 0", done); end
      tests_run++;
      if (req_if.char_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, expected 0", req_if.char_valid); end
      tests_run++;
      if ({req_if.char_ascii, req_if.char_row_index, req_if.char_pos_x, req_if.char_pos_y} !== 36'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got ascii=%h row=%0d x=%0d y=%0d, expected all 0",
                  req_if.char_ascii, req_if.char_row_index, req_if.char_pos_x, req_if.char_pos_y);
      end
   endtask

   task automatic test_basic();
      write_char(6'd0, 8'h41);
      write_char(6'd1, 8'h42);
      build_expected(2, 11'd100, 11'd50);
      render(7'd2, 11'd100, 11'd50, 1'b0, -1, 1'b0);
      tests_run++;
      if (timeout != 0) begin tests_failed++; $display("FAIL basic_timeout: got no done, expected done"); end
      tests_run++;
      if (rec_a.size() != 36) begin tests_failed++; $display("FAIL basic_count: got %0d, expected 36", rec_a.size()); end
      for (int i = 0; i < exp_a.size(); i++) begin
         tests_run++;
         if (i >= rec_a.size() || rec_a[i] !== exp_a[i] || rec_r[i] !== exp_r[i] ||
             rec_x[i] !== exp_x[i] || rec_y[i] !== exp_y[i]) begin
            tests_failed++;
            $display("FAIL basic_req[%0d]: got a=%h r=%0d x=%0d y=%0d, expected a=%h r=%0d x=%0d y=%0d",
                     i, rec_a[i], rec_r[i], rec_x[i], rec_y[i], exp_a[i], exp_r[i], exp_x[i], exp_y[i]);
            break;
         end
      end
      tests_run++;
      if (rec_x.size() < 36 || rec_x[18] !== 11'd109 || rec_a[18] !== 8'h42) begin
         tests_failed++; $display("FAIL basic_b_pos: got x=%0d a=%h, expected x=109 a=42", rec_x[18], rec_a[18]);
      end
      tests_run++;
      if (n_done != 1) begin tests_failed++; $display("FAIL basic_done_pulses: got %0d, expected 1", n_done); end
      tests_run++;
      if (busy_bad != 0) begin tests_failed++; $display("FAIL basic_busy_at_done: got %0d busy cycles, expected 0", busy_bad); end
      tests_run++;
      if (gap_err != 0) begin tests_failed++; $display("FAIL basic_gap: got %0d back-to-back valids, expected 0", gap_err); end
      tests_run++;
      if (busy_c1 !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_rise: got %b, expected 1", busy_c1); end
   endtask

   task automatic test_stall();
      build_expected(2, 11'd100, 11'd50);
      render(7'd2, 11'd100, 11'd50, 1'b1, -1, 1'b0);
      tests_run++;
      if (stall_hits != 1) begin tests_failed++; $display("FAIL stall_hit: got %0d, expected 1", stall_hits); end
      tests_run++;
      if (stall_err != 0) begin tests_failed++; $display("FAIL stall_stable: got %0d unstable cycles, expected 0", stall_err); end
      tests_run++;
      if (rec_a.size() != 36 || timeout != 0) begin tests_failed++; $display("FAIL stall_count: got %0d, expected 36", rec_a.size()); end
      for (int i = 0; i < exp_a.size(); i++) begin
         tests_run++;
         if (i >= rec_a.size() || rec_a[i] !== exp_a[i] || rec_r[i] !== exp_r[i] ||
             rec_x[i] !== exp_x[i] || rec_y[i] !== exp_y[i]) begin
            tests_failed++;
            $display("FAIL stall_req[%0d]: got a=%h r=%0d, expected a=%h r=%0d", i, rec_a[i], rec_r[i], exp_a[i], exp_r[i]);
            break;
         end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 33; i++) write_char(6'(i), 8'(8'h41 + i % 26));
      build_expected(33, 11'd0, 11'd0);
      render(7'd33, 11'd0, 11'd0, 1'b0, -1, 1'b0);
      tests_run++;
      if (rec_a.size() != 594 || timeout != 0) begin tests_failed++; $display("FAIL wrap_count: got %0d, expected 594", rec_a.size()); end
      tests_run++;
      if (rec_x.size() < 594 || rec_x[558] !== 11'd279 || rec_y[558] !== 11'd0) begin
         tests_failed++; $display("FAIL wrap_char31: got x=%0d y=%0d, expected x=279 y=0", rec_x[558], rec_y[558]);
      end
      tests_run++;
      if (rec_x.size() < 594 || rec_x[576] !== 11'd0 || rec_y[576] !== 11'd20) begin
         tests_failed++; $display("FAIL wrap_char32: got x=%0d y=%0d, expected x=0 y=20", rec_x[576], rec_y[576]);
      end
      for (int i = 0; i < exp_a.size(); i++) begin
         tests_run++;
         if (i >= rec_a.size() || rec_a[i] !== exp_a[i] || rec_r[i] !== exp_r[i] ||
             rec_x[i] !== exp_x[i] || rec_y[i] !== exp_y[i]) begin
            tests_failed++;
            $display("FAIL wrap_req[%0d]: got a=%h x=%0d y=%0d, expected a=%h x=%0d y=%0d",
                     i, rec_a[i], rec_x[i], rec_y[i], exp_a[i], exp_x[i], exp_y[i]);
            break;
         end
      end
   endtask

   task automatic test_len_zero();
      render(7'd0, 11'd5, 11'd5, 1'b0, -1, 1'b0);
      tests_run++;
      if (done_cyc != 2) begin tests_failed++; $display("FAIL len0_done_latency: got %0d, expected 2", done_cyc); end
      tests_run++;
      if (valid_seen != 0) begin tests_failed++; $display("FAIL len0_valid: got %0d, expected 0", valid_seen); end
      tests_run++;
      if (n_done != 1) begin tests_failed++; $display("FAIL len0_done_pulses: got %0d, expected 1", n_done); end
   endtask

   task automatic test_back_to_back();
      write_char(6'd0, 8'h41);
      write_char(6'd1, 8'h42);
      render(7'd2, 11'd100, 11'd50, 1'b0, -1, 1'b1);
      tests_run++;
      if (rec_a.size() != 36 || timeout != 0) begin tests_failed++; $display("FAIL restart_count: got %0d, expected 36", rec_a.size()); end
      tests_run++;
      if (n_done != 1) begin tests_failed++; $display("FAIL restart_done: got %0d, expected 1", n_done); end
   endtask

   task automatic test_abort();
      render(7'd2, 11'd100, 11'd50, 1'b0, 7, 1'b0);
      tests_run++;
      if (post_rst_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_valid: got %b, expected 0", post_rst_valid); end
      tests_run++;
      if (post_rst_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, expected 0", post_rst_busy); end
      tests_run++;
      if (post_rst_done != 0 || n_done != 0) begin tests_failed++; $display("FAIL abort_done: got %0d, expected 0", post_rst_done + n_done); end
      tests_run++;
      if (rec_a.size() != 7) begin tests_failed++; $display("FAIL abort_partial: got %0d, expected 7", rec_a.size()); end
      render(7'd2, 11'd100, 11'd50, 1'b0, -1, 1'b0);
      tests_run++;
      if (rec_a.size() < 1 || rec_a[0] !== 8'h41 || rec_r[0] !== 6'd0 || rec_x[0] !== 11'd100 || rec_y[0] !== 11'd50) begin
         tests_failed++;
         $display("FAIL abort_restart_first: got a=%h r=%0d x=%0d y=%0d, expected a=41 r=0 x=100 y=50",
                  rec_a[0], rec_r[0], rec_x[0], rec_y[0]);
      end
      tests_run++;
      if (rec_a.size() != 36) begin tests_failed++; $display("FAIL abort_restart_count: got %0d, expected 36", rec_a.size()); end
   endtask

   task automatic test_blank();
      int exp_n;
      logic [10:0] exp_bx;
`ifdef OSD_SKIP_BLANK_EN
      exp_n = 36;
`else
      exp_n = 54;
`endif
      exp_bx = 11'd218;
      write_char(6'd0, 8'h41);
      write_char(6'd1, 8'h20);
      write_char(6'd2, 8'h42);
      build_expected(3, 11'd200, 11'd30);
      render(7'd3, 11'd200, 11'd30, 1'b0, -1, 1'b0);
      tests_run++;
      if (rec_a.size() != exp_n || timeout != 0) begin tests_failed++; $display("FAIL blank_count: got %0d, expected %0d", rec_a.size(), exp_n); end
      tests_run++;
      if (rec_a.size() < 1 || rec_x[rec_x.size()-1] !== exp_bx || rec_a[rec_a.size()-1] !== 8'h42) begin
         tests_failed++; $display("FAIL blank_b_pos: got x=%0d, expected x=%0d", rec_x[rec_x.size()-1], exp_bx);
      end
      for (int i = 0; i < exp_a.size(); i++) begin
         tests_run++;
         if (i >= rec_a.size() || rec_a[i] !== exp_a[i] || rec_r[i] !== exp_r[i] ||
             rec_x[i] !== exp_x[i] || rec_y[i] !== exp_y[i]) begin
            tests_failed++;
            $display("FAIL blank_req[%0d]: got a=%h r=%0d x=%0d, expected a=%h r=%0d x=%0d",
                     i, rec_a[i], rec_r[i], rec_x[i], exp_a[i], exp_r[i], exp_x[i]);
            break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_len_zero();
      test_back_to_back();
      test_abort();
      test_blank();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/osd_char_seq.md
Name: osd_char_seq

Overview:
Upstream sequencer for the character-glyph ROM stage. It holds an OSD text string in an internal buffer, written from the UDP command path. On a start pulse it walks the string character by character and, for each character, glyph row by glyph row. For every row it presents {ascii, row index, char origin x/y} to the glyph stage using that stage's valid/next handshake. Output is pixel-row requests only; this block never touches pixel data.

Parameters:
CHAR_W, 9, glyph width in pixels; x advance per column.
CHAR_H, 18, glyph rows per character; row index runs 0..CHAR_H-1.
TEXT_DEPTH, 64, text buffer depth in characters.
ADDR_W, 6, text buffer address width (clog2 of TEXT_DEPTH).
COLS, 32, characters per text line before wrapping.
LINE_PITCH, 20, y advance in pixels per wrapped text line (must be at least CHAR_H).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  text buffer write strobe
wr_addr  in  ADDR_W  text buffer write address
wr_data  in  8  ASCII code to store
start  in  1  single-cycle render request
len  in  ADDR_W+1  number of characters to render
origin_x  in  11  x of first character
origin_y  in  11  y of first character
busy  out  1  render in progress
done  out  1  single-cycle pulse when render finishes
char_ascii  out  8  current character code
char_row_index  out  6  current glyph row
char_pos_x  out  11  current character origin x
char_pos_y  out  11  current character origin y (row offset is added downstream)
char_valid  out  1  request valid
char_next  in  1  request consumed (combinational from downstream)

Behaviour:
- Reset: one clock, sync active-high (clk/rst); decided, not configurable.
- All outputs are 0 during and after reset; the FSM is in IDLE. rst asserted mid-render aborts the render: char_valid=0 and busy=0 after that edge, and no done pulse is issued.
- Text buffer: single-clock dual-port RAM. Writes are always accepted, including while busy. A read and a write to the same address in the same cycle return the old data (read-first). Buffer contents are not cleared by rst.
- FSM states: IDLE, FETCH, PRESENT, GAP, FIN.
- IDLE:
  - start=1 latches len, origin_x and origin_y; go to FETCH; busy=1.
  - len is clamped to TEXT_DEPTH.
  - start while busy is ignored.
- len=0: go straight to FIN; done pulses 1 cycle after the start edge; char_valid is never asserted.
- FETCH: issue the read for char index k (1-cycle RAM latency), then go to PRESENT. char_valid rises 2 edges after start is sampled.
- PRESENT:
  - char_valid=1. char_ascii, char_row_index, char_pos_x and char_pos_y are held stable until char_next is sampled.
  - char_next=1 at a clock edge goes to GAP, with char_valid=0 after that edge.
- GAP (exactly one cycle, char_valid=0; the downstream stage needs a low cycle for its rising-edge detect):
  - row < CHAR_H-1: row++, go to PRESENT.
  - Otherwise, if more characters remain: row=0, k++, go to FETCH.
  - Otherwise: go to FIN.
- char_next is ignored whenever char_valid=0.
- FIN: done=1 for one cycle, busy=0, back to IDLE.
- Position arithmetic (incremental adders only, no multipliers; all 11-bit, wrapping mod 2048):
  - col=0 at start.
  - Advancing a character: col++ and x += CHAR_W.
  - If col reaches COLS: col=0, x=origin_x, y += LINE_PITCH.
- Total requests per render: len*CHAR_H (reduced by the optional feature). Minimum cycle spacing: 2 per row, 3 at a character boundary.

Optional Feature:
OSD_SKIP_BLANK_EN
- Defined: in FETCH, a code outside 33..126 (space, control, 127+) emits no rows. The position still advances, and the FSM goes to the next FETCH (or FIN if it was the last character). A string of only blanks yields done with zero char_valid.
- Undefined: every character emits CHAR_H rows regardless of code; the glyph stage renders out-of-range codes from ROM entry 0.

Test Plan:
- Write "AB" at 0..1; start with len=2, origin (100,50); char_next is the 1-cycle echo of char_valid -> 36 requests. A rows 0..17 at x=100,y=50; B rows 0..17 at x=109,y=50. char_valid is low ≥1 cycle between requests. done pulses once; busy falls with done.
- Hold char_next low for 10 cycles during A row 5 -> outputs stable, char_valid stays 1, no row skipped.
- COLS=32, len=33, origin (0,0) -> char 32 at x=0, y=20; char 31 at x=279.
- len=0 -> done 1 cycle after start, no char_valid. start pulsed again while busy -> ignored; the request count is unchanged.
- rst asserted on row 7 of char 0 -> char_valid=0 and busy=0 after the edge, no done. A new start afterwards renders from char 0, row 0.
- "A B", len=3: with OSD_SKIP_BLANK_EN -> 36 requests, B at x=origin+18. Without the macro -> 54 requests; the space emits rows at x=origin+9.
